// File: rtl/shift_right_seq_if.sv
// rtl/shift_right_seq_if.sv - start/busy/done handshake bundle for the right shifter
interface shift_right_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             arith;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] inp;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, arith, shamt, inp,
    input  out, busy, done
  );

  modport slave (
    input  start, arith, shamt, inp,
    output out, busy, done
  );
endinterface

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - multi-cycle right shifter (SRL/SRA), STEP bits per cycle
module shift_right_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic              clk,
  input logic              rst_n,
  shift_right_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       count_q, count_d;
  logic             fill_q, fill_d;
  logic [4:0]       n;
  logic [WIDTH-1:0] fill_mask;

  // The fill bit is resolved at accept time, so the operand's sign survives
  // however far the working register has already been shifted.
  assign n         = (count_q < STEP_AMT) ? count_q : STEP_AMT;
  assign fill_mask = fill_q ? ~({WIDTH{1'b1}} >> n) : {WIDTH{1'b0}};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          work_d  = bus.inp;
          count_d = bus.shamt;
          fill_d  = bus.arith & bus.inp[WIDTH-1];
          state_d = (bus.shamt == 5'd0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = (work_q >> n) | fill_mask;
        count_d = count_q - n;
        if (count_q == n) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= {WIDTH{1'b0}};
      count_q <= 5'd0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.out  = work_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// tb/tb_shift_right_seq.sv - directed self-checking bench for shift_right_seq
module tb_shift_right_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_right_seq_if bus1 ();
  shift_right_seq_if bus4 ();

  shift_right_seq #(.WIDTH(32), .STEP(1)) u_step1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  shift_right_seq #(.WIDTH(32), .STEP(4)) u_step4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation on the STEP=1 instance and reports what it saw;
  // latency counts negedges from accept edge to the first done sample.
  task automatic run_op(input logic arith, input logic [4:0] shamt, input logic [31:0] inp,
                        output int busy_cycles, output int lat, output logic [31:0] res,
                        output logic seen_done);
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.arith = arith;
    bus1.shamt = shamt;
    bus1.inp   = inp;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.inp   = 32'hDEAD_BEEF;
    lat = 1;
    busy_cycles = 0;
    while (!bus1.done && lat < 100) begin
      if (bus1.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res = bus1.out;
    seen_done = bus1.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus1.out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want %h", bus1.out, 32'h0); end
    checks++;
    if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    checks++;
    if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus1.done); end
    checks++;
    if (bus4.out !== 32'h0) begin errors++; $display("FAIL reset_out4 got %h want %h", bus4.out, 32'h0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_logical();
    int bc, lat;
    logic [31:0] res;
    logic sd;
    run_op(1'b0, 5'd4, 32'h8000_0000, bc, lat, res, sd);
    checks++;
    if (sd !== 1'b1) begin errors++; $display("FAIL srl_done_seen got %b want 1", sd); end
    checks++;
    if (res !== 32'h0800_0000) begin errors++; $display("FAIL srl_out got %h want %h", res, 32'h0800_0000); end
    checks++;
    if (bc != 4) begin errors++; $display("FAIL srl_busy_cycles got %0d want 4", bc); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL srl_latency got %0d want 5", lat); end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b0) begin errors++; $display("FAIL srl_done_pulse got %b want 0", bus1.done); end
    checks++;
    if (bus1.out !== 32'h0800_0000) begin errors++; $display("FAIL srl_hold got %h want %h", bus1.out, 32'h0800_0000); end
  endtask

  task automatic test_arith();
    int bc, lat;
    logic [31:0] res;
    logic sd;
    run_op(1'b1, 5'd4, 32'h8000_0000, bc, lat, res, sd);
    checks++;
    if (res !== 32'hF800_0000) begin errors++; $display("FAIL sra_neg got %h want %h", res, 32'hF800_0000); end
    run_op(1'b1, 5'd4, 32'h7FFF_FFF0, bc, lat, res, sd);
    checks++;
    if (res !== 32'h07FF_FFFF) begin errors++; $display("FAIL sra_pos got %h want %h", res, 32'h07FF_FFFF); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL sra_latency got %0d want 5", lat); end
  endtask

  task automatic test_edge_amounts();
    int bc, lat;
    logic [31:0] res;
    logic sd;
    run_op(1'b0, 5'd0, 32'h1234_5678, bc, lat, res, sd);
    checks++;
    if (res !== 32'h1234_5678) begin errors++; $display("FAIL zero_out got %h want %h", res, 32'h1234_5678); end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++;
    if (bc != 0) begin errors++; $display("FAIL zero_busy got %0d want 0", bc); end
    run_op(1'b0, 5'd31, 32'hFFFF_FFFF, bc, lat, res, sd);
    checks++;
    if (res !== 32'h0000_0001) begin errors++; $display("FAIL srl31_out got %h want %h", res, 32'h1); end
    checks++;
    if (lat != 32) begin errors++; $display("FAIL srl31_latency got %0d want 32", lat); end
    checks++;
    if (bc != 31) begin errors++; $display("FAIL srl31_busy got %0d want 31", bc); end
    run_op(1'b1, 5'd31, 32'hFFFF_FFFF, bc, lat, res, sd);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_out got %h want %h", res, 32'hFFFF_FFFF); end
  endtask

  task automatic test_step4();
    int bc, lat;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.arith = 1'b1;
    bus4.shamt = 5'd5;
    bus4.inp   = 32'hF000_0000;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.inp   = 32'h0;
    bus4.arith = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.out !== 32'hFF00_0000) begin errors++; $display("FAIL step4_partial got %h want %h", bus4.out, 32'hFF00_0000); end
    lat = 2;
    bc = 1;
    while (!bus4.done && lat < 100) begin
      if (bus4.busy) bc++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus4.out !== 32'hFF80_0000) begin errors++; $display("FAIL step4_out got %h want %h", bus4.out, 32'hFF80_0000); end
    checks++;
    if (bc != 2) begin errors++; $display("FAIL step4_busy got %0d want 2", bc); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL step4_latency got %0d want 3", lat); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.arith = 1'b0;
    bus1.shamt = 5'd4;
    bus1.inp   = 32'h8000_0000;
    @(negedge clk);
    bus1.start = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.arith = 1'b1;
    bus1.shamt = 5'd1;
    bus1.inp   = 32'hFFFF_FFFF;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 3;
    while (!bus1.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus1.out !== 32'h0800_0000) begin errors++; $display("FAIL ignore_out got %h want %h", bus1.out, 32'h0800_0000); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", lat); end
  endtask

  task automatic test_back_to_back();
    int bc, lat;
    logic [31:0] res;
    logic sd;
    run_op(1'b0, 5'd2, 32'h0000_0010, bc, lat, res, sd);
    checks++;
    if (res !== 32'h0000_0004) begin errors++; $display("FAIL b2b_first got %h want %h", res, 32'h4); end
    bus1.start = 1'b1;
    bus1.shamt = 5'd0;
    bus1.inp   = 32'hA5A5_A5A5;
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b1) begin errors++; $display("FAIL b2b_done_second got %b want 1", bus1.done); end
    checks++;
    if (bus1.out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL b2b_out got %h want %h", bus1.out, 32'hA5A5_A5A5); end
    bus1.shamt = 5'd1;
    bus1.inp   = 32'h0000_0100;
    @(negedge clk);
    bus1.start = 1'b0;
    checks++;
    if (bus1.done !== 1'b0 || bus1.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_shift_start got done=%b busy=%b want done=0 busy=1", bus1.done, bus1.busy);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b1 || bus1.out !== 32'h0000_0080) begin
      errors++;
      $display("FAIL b2b_shift_result got done=%b out=%h want done=1 out=%h", bus1.done, bus1.out, 32'h80);
    end
  endtask

  task automatic test_reset_mid_shift();
    int bc, lat;
    logic [31:0] res;
    logic sd;
    logic saw_done;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.arith = 1'b1;
    bus1.shamt = 5'd20;
    bus1.inp   = 32'hFFFF_FFFF;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.out !== 32'h0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got out=%h busy=%b done=%b want 0/0/0", bus1.out, bus1.busy, bus1.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus1.done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", saw_done); end
    run_op(1'b0, 5'd8, 32'h00F0_0000, bc, lat, res, sd);
    checks++;
    if (res !== 32'h0000_F000 || lat != 9) begin
      errors++;
      $display("FAIL rst_recover got out=%h lat=%0d want out=%h lat=9", res, lat, 32'h0000_F000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus1.start = 1'b0; bus1.arith = 1'b0; bus1.shamt = 5'd0; bus1.inp = 32'h0;
    bus4.start = 1'b0; bus4.arith = 1'b0; bus4.shamt = 5'd0; bus4.inp = 32'h0;
    test_reset();
    test_logical();
    test_arith();
    test_edge_amounts();
    test_step4();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multi-cycle right shifter for the datapath's shift instructions (SRL, SRA, SRLV, SRAV). It is the right-direction counterpart of the fixed left shifter used for branch-offset scaling. Operand and amount are captured on a start strobe. The operand is then shifted STEP bit positions per cycle, and a one-cycle done pulse is issued when the held result is valid. It sits beside the ALU and is sequenced by the control FSM through the start/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width. The design supports 32 only; the parameter exists for documentation and bench use.
- STEP, 1, maximum bit positions shifted per cycle. Legal values: 1, 2, 4, 8.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request strobe; sampled on the rising edge of clk.
- arith  input  1  1 = arithmetic shift (SRA, sign fill); 0 = logical shift (SRL, zero fill).
- shamt  input  5  shift amount, 0..31.
- inp  input  32  operand.
- out  output  32  result; held stable between done and the next accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; out is valid in the same cycle.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (rst_n low, any state, immediate) sets:
  - state = IDLE
  - out = 32'h0000_0000
  - internal count = 0
  - busy = 0, done = 0
- Start is accepted when start = 1 and state is IDLE or DONE. On acceptance:
  - latch inp into the working register
  - latch shamt into count
  - latch arith into the fill mode
- Transitions after acceptance:
  - shamt = 0 → DONE.
  - shamt > 0 → SHIFT.
- Start is ignored in SHIFT. No queueing, no error flag.
- Each SHIFT cycle:
  - n = min(count, STEP).
  - Working register shifts right by n.
  - Vacated MSBs are filled with the latched bit 31 of the operand if arith = 1, otherwise with 0.
  - count -= n.
  - When count reaches 0, go to DONE.
- Sign-fill source is the operand's original bit 31, which is never lost during shifting.
- DONE:
  - done = 1 for exactly one cycle.
  - A new start in this cycle is accepted (back-to-back). Otherwise go to IDLE.
- out is the working register. It changes only during SHIFT or on an accepted start. Once done pulses, the result holds until the next acceptance.
- busy = 1 exactly when state = SHIFT.
- Inputs inp, shamt and arith are don't-care except in the accept cycle.

## Timing
- k = ceil(shamt / STEP).
- Start accepted at edge T:
  - shamt = 0: DONE after edge T; done is high between edges T and T+1. Latency is 1 cycle.
  - shamt > 0: SHIFT after edge T; shifts occur at edges T+1 .. T+k; DONE after edge T+k; done is high between edges T+k and T+k+1. Latency is k+1 cycles.
- busy is high from after edge T until edge T+k, for k cycles.
- During SHIFT, out shows partial results. Consumers sample out only when done = 1 or in IDLE.
- Back-to-back: a start in the DONE cycle makes the next operation begin immediately. done drops for that next cycle unless its shamt = 0, in which case done stays high a second consecutive cycle.
- Reset mid-SHIFT: everything clears at once. No done pulse is produced for the aborted operation, and out reads 0.
- Worst case: shamt = 31 with STEP = 1 gives 32 cycles; with STEP = 8 it gives 5 cycles.

## Test plan
- Logical shift, STEP=1: inp=32'h8000_0000, shamt=4, arith=0.
  - Expect busy for 4 cycles, done on cycle 5, out=32'h0800_0000.
- Arithmetic shift, STEP=1: inp=32'h8000_0000, shamt=4, arith=1.
  - Expect out=32'hF800_0000.
  - Also inp=32'h7FFF_FFF0, shamt=4, arith=1: expect out=32'h07FF_FFFF.
- Edge amounts:
  - shamt=0, inp=32'h1234_5678: done one cycle after start, busy never high, out=32'h1234_5678.
  - shamt=31, inp=32'hFFFF_FFFF: arith=0 gives out=32'h0000_0001; arith=1 gives out=32'hFFFF_FFFF.
- STEP=4, inp=32'hF000_0000, shamt=5, arith=1:
  - Expect shifts of 4 then 1, busy for 2 cycles, out=32'hFF80_0000.
- Handshake:
  - Start pulsed mid-SHIFT with different data is ignored; the original result is delivered.
  - Start in the DONE cycle with shamt=0 and inp=32'hA5A5_A5A5: done is high for two consecutive cycles, and out=32'hA5A5_A5A5 in the second.
- Reset: assert rst_n=0 asynchronously during SHIFT.
  - Expect out, busy and done all 0 immediately, no done pulse, and a subsequent start operating normally.
